// File: rtl/lru_tick_tracker.sv
// lru_tick_tracker
// Writer side of the LRU tick store: stamps a global counter into the touched
// way of a set, exposes the ticks of one queried set, and renormalizes the
// whole array (one set per cycle) when the counter saturates.

`ifndef CACHE_E
`define CACHE_E 4
`endif
`ifndef CACHE_S
`define CACHE_S 4
`endif

module lru_tick_tracker #(
    parameter int SET_SIZE   = `CACHE_E,
    parameter int SET_COUNT  = `CACHE_S,
    parameter int KEY_WIDTH  = $clog2(SET_SIZE),
    parameter int SET_WIDTH  = $clog2(SET_COUNT),
    parameter int TICK_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  touch_valid,
    output logic                  touch_ready,
    input  logic [SET_WIDTH-1:0]  touch_set,
    input  logic [KEY_WIDTH-1:0]  touch_way,
    input  logic [SET_WIDTH-1:0]  query_set,
    output logic [TICK_WIDTH-1:0] tick_out [SET_SIZE],
    output logic                  busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [TICK_WIDTH-1:0] MAX_TICK    = '1;
    localparam logic [TICK_WIDTH-1:0] FIRST_TICK  = TICK_WIDTH'(1);
    localparam int unsigned           SET_COUNT_U = SET_COUNT;
    localparam int unsigned           SET_SIZE_U  = SET_SIZE;
    localparam int unsigned           LAST_SET    = SET_COUNT - 1;

    state_t                state_q;
    state_t                state_d;
    logic [TICK_WIDTH-1:0] now;
    logic [SET_WIDTH-1:0]  clr_idx;
    logic [TICK_WIDTH-1:0] ticks [SET_COUNT][SET_SIZE];

    logic accept;
    logic touch_set_ok;
    logic touch_way_ok;
    logic query_set_ok;
    logic stamp;
    logic saturating;
    logic clear_last;

    // Sets beyond SET_COUNT only exist when SET_COUNT is not a power of two;
    // such touches complete the handshake but leave the array and counter alone.
    assign touch_set_ok = 32'(touch_set) < SET_COUNT_U;
    assign touch_way_ok = 32'(touch_way) < SET_SIZE_U;
    assign query_set_ok = 32'(query_set) < SET_COUNT_U;

    assign accept     = touch_valid && (state_q == IDLE);
    assign stamp      = accept && touch_set_ok;
    assign saturating = stamp && (now == MAX_TICK);
    assign clear_last = 32'(clr_idx) == LAST_SET;

    assign touch_ready = (state_q == IDLE);
    assign busy        = (state_q == CLEAR);

    // State register for the IDLE/CLEAR controller.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            // NOTE: all clocked state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of block order.
            state_q <= state_d;
        end
    end

    // Next-state logic: enter CLEAR on the saturating stamp, leave after the last set.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the case statement can infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (saturating) state_d = CLEAR;
            CLEAR:   if (clear_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Global tick counter and clear index; the counter restarts at 1 so a
    // stamped way is never mistaken for an untouched (tick 0) way.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            now     <= FIRST_TICK;
            clr_idx <= '0;
        end else begin
            if (stamp) begin
                if (now == MAX_TICK) begin
                    now     <= FIRST_TICK;
                    clr_idx <= '0;
                end else begin
                    now <= now + FIRST_TICK;
                end
            end
            if (state_q == CLEAR && !clear_last) begin
                clr_idx <= clr_idx + 1'b1;
            end
        end
    end

    // Tick array: stamp on accepted touches, wipe one set per cycle in CLEAR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the array is deliberately built from resettable flops rather
            // than RAM, because reset must zero every tick asynchronously.
            for (int s = 0; s < SET_COUNT; s++) begin
                for (int w = 0; w < SET_SIZE; w++) begin
                    ticks[s][w] <= '0;
                end
            end
        end else if (state_q == CLEAR) begin
            for (int w = 0; w < SET_SIZE; w++) begin
                ticks[clr_idx][w] <= '0;
            end
        end else if (stamp && touch_way_ok) begin
            ticks[touch_set][touch_way] <= now;
        end
    end

    // Combinational read of the queried set; out-of-range sets read as zero.
    always_comb begin
        for (int w = 0; w < SET_SIZE; w++) begin
            tick_out[w] = '0;
        end
        if (query_set_ok) begin
            for (int w = 0; w < SET_SIZE; w++) begin
                tick_out[w] = ticks[query_set][w];
            end
        end
    end

endmodule

// File: tb/tb_lru_tick_tracker.sv
// Self-checking bench for lru_tick_tracker: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the tick store.

module tb_lru_tick_tracker;

    localparam int SS  = 4;
    localparam int SC  = 4;
    localparam int TW  = 4;
    localparam int KW  = 2;
    localparam int SW  = 2;
    localparam int MAX = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          touch_valid;
    logic          touch_ready;
    logic [SW-1:0] touch_set;
    logic [KW-1:0] touch_way;
    logic [SW-1:0] query_set;
    logic [TW-1:0] tick_out [SS];
    logic          busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: plain integer array, counter and remaining clear cycles.
    int model [SC][SS];
    int now_m;
    int clear_left;
    bit last_acc;

    lru_tick_tracker #(
        .SET_SIZE  (SS),
        .SET_COUNT (SC),
        .KEY_WIDTH (KW),
        .SET_WIDTH (SW),
        .TICK_WIDTH(TW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .touch_valid(touch_valid),
        .touch_ready(touch_ready),
        .touch_set  (touch_set),
        .touch_way  (touch_way),
        .query_set  (query_set),
        .tick_out   (tick_out),
        .busy       (busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SC; s++)
            for (int w = 0; w < SS; w++)
                model[s][w] = 0;
        now_m      = 1;
        clear_left = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " ready"}, 32'(touch_ready), 32'(clear_left == 0));
        check({tag, " busy"},  32'(busy),        32'(clear_left != 0));
        for (int w = 0; w < SS; w++)
            check($sformatf("%s tick q%0d w%0d", tag, query_set, w),
                  32'(tick_out[w]), 32'(model[query_set][w]));
    endtask

    // One clock: check at the falling edge, advance the model on the rising
    // edge with the inputs that were present, then leave 1 time unit after it.
    task automatic cycle();
        @(negedge clk);
        check_outputs("cyc");
        last_acc = touch_valid && touch_ready;
        @(posedge clk);
        if (clear_left > 0) begin
            for (int w = 0; w < SS; w++) model[SC - clear_left][w] = 0;
            clear_left--;
        end else if (touch_valid) begin
            model[touch_set][touch_way] = now_m;
            if (now_m == MAX) begin
                now_m      = 1;
                clear_left = SC;
            end else begin
                now_m++;
            end
        end
        #1;
    endtask

    task automatic touch(input int s, input int w);
        touch_valid = 1'b1;
        touch_set   = SW'(s);
        touch_way   = KW'(w);
        cycle();
        touch_valid = 1'b0;
        #1;
    endtask

    // Asynchronous reset with an immediate check, released after a clock edge.
    task automatic do_reset(input string tag);
        touch_valid = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check({tag, " rst ready"}, 32'(touch_ready), 32'd1);
        check({tag, " rst busy"},  32'(busy),        32'd0);
        for (int q = 0; q < SC; q++) begin
            query_set = SW'(q);
            #1;
            for (int w = 0; w < SS; w++)
                check($sformatf("%s rst q%0d w%0d", tag, q, w), 32'(tick_out[w]), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        int n;
        int iter;
        int acc_cnt;

        reset       = 1'b1;
        touch_valid = 1'b0;
        touch_set   = '0;
        touch_way   = '0;
        query_set   = '0;
        last_acc    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // 1: reset state seen on every set
        do_reset("t1");
        for (int q = 0; q < SC; q++) begin
            query_set = SW'(q);
            cycle();
        end

        // 2: three back-to-back touches to set 2
        touch(2, 1);
        touch(2, 3);
        touch(2, 1);
        query_set = 2'd2;
        #1;
        check("t2 w0", 32'(tick_out[0]), 32'd0);
        check("t2 w1", 32'(tick_out[1]), 32'd3);
        check("t2 w2", 32'(tick_out[2]), 32'd0);
        check("t2 w3", 32'(tick_out[3]), 32'd2);

        // 3: touch and query the same set in one cycle
        do_reset("t3");
        query_set   = 2'd1;
        touch_valid = 1'b1;
        touch_set   = 2'd1;
        touch_way   = 2'd0;
        #1;
        check("t3 pre", 32'(tick_out[0]), 32'd0);
        cycle();
        touch_valid = 1'b0;
        #1;
        check("t3 post", 32'(tick_out[0]), 32'd1);

        // 4: saturation and renormalization
        do_reset("t4");
        for (int i = 0; i < 14; i++) touch(0, i % 4);
        query_set = 2'd3;
        touch(3, 2);
        check("t4 stamp max", 32'(tick_out[2]), 32'd15);
        check("t4 busy", 32'(busy), 32'd1);
        n = 0;
        while (touch_ready !== 1'b1 && n < 20) begin
            query_set = SW'(n % SC);
            cycle();
            n++;
        end
        check("t4 clear len", 32'(n), 32'd4);
        query_set = 2'd1;
        touch(1, 3);
        check("t4 first tick", 32'(tick_out[3]), 32'd1);

        // 5: touch held through CLEAR is accepted exactly once afterwards
        do_reset("t5");
        for (int i = 0; i < 14; i++) touch(2, i % 4);
        touch_valid = 1'b1;
        touch_set   = 2'd1;
        touch_way   = 2'd1;
        query_set   = 2'd1;
        acc_cnt = 0;
        iter    = 0;
        while (acc_cnt < 2 && iter < 20) begin
            cycle();
            iter++;
            if (last_acc) acc_cnt++;
        end
        touch_valid = 1'b0;
        #1;
        check("t5 cycles", 32'(iter), 32'd6);
        check("t5 tick", 32'(tick_out[1]), 32'd1);

        // 6: reset during the second CLEAR cycle
        do_reset("t6a");
        for (int i = 0; i < 14; i++) touch(0, i % 4);
        touch(3, 2);
        cycle();
        #2;
        do_reset("t6");
        query_set = 2'd0;
        touch(0, 0);
        check("t6 first tick", 32'(tick_out[0]), 32'd1);

        // Randomized traffic, including repeated saturations
        do_reset("rnd");
        repeat (400) begin
            touch_valid = ($urandom_range(0, 3) != 0);
            touch_set   = SW'($urandom_range(0, SC - 1));
            touch_way   = KW'($urandom_range(0, SS - 1));
            query_set   = SW'($urandom_range(0, SC - 1));
            cycle();
        end
        touch_valid = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lru_tick_tracker.md
# lru_tick_tracker

Maintains the per-way access timestamps ("ticks") for every set of the set-associative cache and presents the tick vector of one selected set to the LRU victim selector. The victim selector picks the way with the smallest tick. This block is the writer side of that interface. It stamps the current value of a global counter into a way on each hit or fill. When the counter saturates, it renormalizes the tick array by clearing it one set per cycle.

## Interface
Parameters:
- SET_SIZE, default `CACHE_E`: ways per set.
- SET_COUNT, default `CACHE_S`: number of sets.
- KEY_WIDTH, default $clog2(SET_SIZE): way index width.
- SET_WIDTH, default $clog2(SET_COUNT): set index width.
- TICK_WIDTH, default 32: width of the counter and of each tick. The LRU consumer expects 32.

Ports:
- clk, in, 1: single clock. All state updates on the rising edge.
- reset, in, 1: asynchronous, active-high. Clears all state.
- touch_valid, in, 1: request to stamp a way.
- touch_ready, out, 1: block can accept a touch.
- touch_set, in, SET_WIDTH: set being accessed.
- touch_way, in, KEY_WIDTH: way being accessed.
- query_set, in, SET_WIDTH: set whose ticks drive tick_out.
- tick_out, out, TICK_WIDTH × SET_SIZE (unpacked [SET_SIZE]): ticks of query_set, combinational read of the array.
- busy, out, 1: renormalization in progress.

## Operation
- State: tick array ticks[SET_COUNT][SET_SIZE]; global counter `now`; FSM {IDLE, CLEAR}; clear index clr_idx (SET_WIDTH).
- Reset:
  - all ticks = 0, now = 1, FSM = IDLE, clr_idx = 0.
  - Outputs: touch_ready = 1, busy = 0, tick_out = 0 for all ways.
- Ticks of 0 mean never touched, so these ways are oldest.
- touch_ready = (FSM == IDLE). busy = (FSM == CLEAR). Both are pure functions of state.
- Accepted touch (touch_valid & touch_ready) in IDLE:
  - ticks[touch_set][touch_way] <= now.
  - If now < MAX (MAX = 2^TICK_WIDTH − 1): now <= now + 1, stay in IDLE.
  - If now == MAX: the write still happens, now <= 1, clr_idx <= 0, go to CLEAR.
- touch_set ≥ SET_COUNT (non-power-of-2 SET_COUNT only): the touch is accepted (handshake completes), but there is no array write and no change to now.
- CLEAR, each cycle:
  - ticks[clr_idx][*] <= 0.
  - If clr_idx == SET_COUNT − 1: go to IDLE. Otherwise clr_idx <= clr_idx + 1.
- The just-stamped MAX entry is also cleared. Loss of recency order across a renormalization is accepted by design. now never wraps to 0.
- touch_valid while in CLEAR is not accepted and has no effect. The requester holds it.
- query_set is read in every state. During CLEAR, tick_out shows the partially cleared array.
- query_set ≥ SET_COUNT: tick_out = 0.

## Timing
- Touch write latency: 1 cycle. A touch accepted at edge N is visible on tick_out from edge N onward, i.e. in the cycle after acceptance.
- A touch and a query of the same set in the same cycle: tick_out shows the pre-write value.
- Back-to-back touches: one per cycle in IDLE, with no bubble.
- Renormalization:
  - The touch at now == MAX is followed by exactly SET_COUNT cycles with touch_ready = 0.
  - touch_ready returns high on the cycle after set SET_COUNT − 1 is cleared.
- reset asserted at any time (including mid-CLEAR) immediately forces the reset state, independent of clk. Operation resumes on the first edge after deassertion.

## Test plan
Unless stated otherwise, benches use SET_SIZE=4, SET_COUNT=4, TICK_WIDTH=4 (MAX=15).

1. Reset, then query sets 0..3 → tick_out all 0, touch_ready=1, busy=0.
2. Touch (set 2, way 1), then (2, 3), then (2, 1) on consecutive cycles → query 2 shows ticks {0, 3, 0, 2}. Set 2 way 0 remains the LRU candidate.
3. Touch (1, 0) and query set 1 in the same cycle → tick_out[0] = 0 that cycle and 1 the next.
4. Saturation:
   - Stimulus: 14 touches to set 0 ways cycling 0..3, then a 15th touch to (3, 2) with now == 15.
   - Required: (3, 2) reads 15 for one cycle, then touch_ready=0 and busy=1 for exactly 4 cycles while sets 0..3 read 0 in order.
   - Then touch_ready=1. The next touch writes tick 1.
5. touch_valid held high through CLEAR → no array change until touch_ready returns. The held touch is then accepted once and writes tick 1.
6. Assert reset during the 2nd CLEAR cycle → all ticks 0, busy=0, touch_ready=1 immediately. The first touch after deassertion writes tick 1.
